// File: rtl/array_7_ctrl_if.sv
// Request/response channel between a requester and array_7_ctrl; 0-cycle wiring, valid/ready on both directions.
interface array_7_ctrl_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 216
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wmask;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wmask, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/array_7_ctrl.sv
// RW0 port controller for a 128x216 masked-write SRAM: zero-fills on reset, then issues requests the same cycle they are accepted.
// Reads return 2 cycles after accept through a 2-entry buffer; req_ready drops while buffered plus in-flight reads reach 2.
module array_7_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 216,
  parameter int DEPTH  = 128
) (
  input  logic              clock,
  input  logic              reset,
  array_7_ctrl_if.slave     bus,
  output logic              init_done,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [DATA_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  typedef enum logic [1:0] {WAIT, INIT, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              inflight;
  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic [DATA_W-1:0] rbuf [2];

  logic accept;
  logic rd_accept;
  logic capture;
  logic pop;

  // Reserve a buffer slot for every read that is already in flight.
  assign bus.req_ready = (state == RUN) && ((count + {1'b0, inflight}) < 2'd2);
  assign accept        = bus.req_valid && bus.req_ready;
  assign rd_accept     = accept && !bus.req_write;
  assign capture       = inflight;
  assign bus.resp_valid = (count != 2'd0);
  assign bus.resp_rdata = rbuf[rd_ptr];
  assign pop           = bus.resp_valid && bus.resp_ready;

  always_comb begin
    RW0_en    = 1'b0;
    RW0_wmode = 1'b0;
    RW0_addr  = '0;
    RW0_wmask = '0;
    RW0_wdata = '0;
    if (state == INIT) begin
      RW0_en    = 1'b1;
      RW0_wmode = 1'b1;
      RW0_addr  = init_cnt;
      RW0_wmask = '1;
    end else if (accept) begin
      RW0_en    = 1'b1;
      RW0_wmode = bus.req_write;
      RW0_addr  = bus.req_addr;
      if (bus.req_write) begin
        RW0_wmask = bus.req_wmask;
        RW0_wdata = bus.req_wdata;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= WAIT;
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        WAIT: state <= INIT;
        INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= 1'b0;
      count    <= 2'd0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      inflight <= rd_accept;
      if (capture) wr_ptr <= ~wr_ptr;
      if (pop)     rd_ptr <= ~rd_ptr;
      case ({capture, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // RW0_rdata is only valid the cycle after the read enable, which is exactly when inflight is set.
  always_ff @(posedge clock) begin
    if (capture) rbuf[wr_ptr] <= RW0_rdata;
  end

  overflow_chk: assert property (@(posedge clock) disable iff (!reset) !(capture && count == 2'd2))
    else $error("array_7_ctrl: read capture into full response buffer");

endmodule

// File: tb/tb_array_7_ctrl.sv
// Directed bench for array_7_ctrl with a behavioural 128x216 masked-write SRAM on RW0.
module tb_array_7_ctrl;
  localparam int AW = 7;
  localparam int DW = 216;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          init_done;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en;
  logic          RW0_wmode;
  logic [DW-1:0] RW0_wmask;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata;
  logic [DW-1:0] mem [128];

  int nchecks = 0;
  int nerr    = 0;

  array_7_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  array_7_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(128)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus),
    .init_done (init_done),
    .RW0_addr  (RW0_addr),
    .RW0_en    (RW0_en),
    .RW0_wmode (RW0_wmode),
    .RW0_wmask (RW0_wmask),
    .RW0_wdata (RW0_wdata),
    .RW0_rdata (RW0_rdata)
  );

  always #5 clock = ~clock;

  // SRAM model: masked write, registered read data.
  always @(posedge clock) begin
    if (RW0_en) begin
      if (RW0_wmode) mem[RW0_addr] <= (mem[RW0_addr] & ~RW0_wmask) | (RW0_wdata & RW0_wmask);
      else           RW0_rdata <= mem[RW0_addr];
    end
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] pat(input int k);
    logic [7:0] b;
    b = 8'(8'h10 + k);
    return {27{b}};
  endfunction

  // Called in the first INIT cycle; leaves the bench in the first RUN cycle.
  task automatic run_init(input string tag);
    logic [DW-1:0] ones;
    ones = '1;
    for (int i = 0; i < 128; i++) begin
      chk({tag, "_ctl"}, {RW0_en, RW0_wmode, bus.req_ready, init_done, bus.resp_valid, RW0_addr},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'(i)});
      chk({tag, "_mask"}, RW0_wmask, ones);
      chk({tag, "_data"}, RW0_wdata, '0);
      tick();
    end
    chk({tag, "_done"}, {init_done, bus.req_ready, RW0_en}, {1'b1, 1'b1, 1'b0});
  endtask

  initial begin
    logic [DW-1:0] lo108;
    logic [DW-1:0] ones;
    logic [DW-1:0] a5;
    int acc;
    int issued;
    int got;

    lo108 = {{108{1'b0}}, {108{1'b1}}};
    ones  = '1;
    a5    = {27{8'hA5}};
    for (int i = 0; i < 128; i++) mem[i] = '1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wmask  = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;

    #1 reset = 1'b0;
    tick(); tick(); tick();
    chk("rst_ctl", {bus.req_ready, bus.resp_valid, init_done, RW0_en, RW0_wmode}, '0);
    chk("rst_bus", {RW0_addr, RW0_wmask, RW0_wdata}, '0);

    reset = 1'b1;
    #1 chk("wait_en", RW0_en, 1'b0);
    tick();
    run_init("init");

    // Masked write to 5, then reads of 5 and 6.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 7'd5;
    bus.req_wdata = ones; bus.req_wmask = lo108;
    #1;
    chk("wr5_ctl", {bus.req_ready, RW0_en, RW0_wmode, RW0_addr}, {1'b1, 1'b1, 1'b1, 7'd5});
    chk("wr5_mask", RW0_wmask, lo108);
    tick();
    bus.req_write = 1'b0;
    #1;
    chk("rd5_ctl", {bus.req_ready, RW0_en, RW0_wmode, RW0_addr}, {1'b1, 1'b1, 1'b0, 7'd5});
    chk("rd5_zero", {RW0_wmask, RW0_wdata}, '0);
    tick();
    bus.req_addr = 7'd6;
    #1 chk("rd6_rdy", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    #1;
    chk("rd5_resp", {bus.resp_valid, bus.req_ready}, {1'b1, 1'b0});
    chk("rd5_data", bus.resp_rdata, lo108);
    bus.resp_ready = 1'b1;
    tick();
    chk("rd6_resp", {bus.resp_valid, bus.req_ready}, {1'b1, 1'b1});
    chk("rd6_data", bus.resp_rdata, '0);
    tick();
    chk("rd6_empty", bus.resp_valid, 1'b0);
    bus.resp_ready = 1'b0;

    // Write then read the same address on the next cycle.
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 7'd9;
    bus.req_wdata = a5; bus.req_wmask = ones;
    tick();
    bus.req_write = 1'b0;
    #1 chk("rd9_rdy", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    #1 chk("rd9_early", bus.resp_valid, 1'b0);
    tick();
    chk("rd9_valid", bus.resp_valid, 1'b1);
    chk("rd9_data", bus.resp_rdata, a5);
    bus.resp_ready = 1'b1;
    tick();
    chk("rd9_empty", bus.resp_valid, 1'b0);
    bus.resp_ready = 1'b0;

    // Distinct patterns at 30..49 for the ordering tests.
    for (int k = 0; k < 20; k++) begin
      bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 7'(30 + k);
      bus.req_wdata = pat(k); bus.req_wmask = ones;
      tick();
    end
    bus.req_write = 1'b0;
    bus.req_wdata = '0;

    // Consumer stalled: only two reads fit.
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      bus.req_valid = 1'b1; bus.req_addr = 7'(30 + acc);
      #1;
      if (bus.req_ready) acc++;
      tick();
    end
    bus.req_valid = 1'b0;
    chk("bp_accepts", 32'(acc), 32'd2);
    #1;
    chk("bp_full", {bus.req_ready, bus.resp_valid}, {1'b0, 1'b1});
    chk("bp_head0", bus.resp_rdata, pat(0));
    bus.resp_ready = 1'b1;
    tick();
    chk("bp_head1", {bus.resp_valid, bus.req_ready}, {1'b1, 1'b1});
    chk("bp_data1", bus.resp_rdata, pat(1));
    tick();
    chk("bp_empty", bus.resp_valid, 1'b0);

    // Streaming reads with the consumer always ready.
    issued = 0;
    got = 0;
    for (int c = 0; c < 100 && got < 20; c++) begin
      bus.req_valid = (issued < 20);
      bus.req_addr  = 7'(30 + (issued % 20));
      #1;
      if (bus.resp_valid) begin
        chk("stream_data", bus.resp_rdata, pat(got));
        got++;
      end
      if (bus.req_valid && bus.req_ready) issued++;
      tick();
    end
    bus.req_valid = 1'b0;
    chk("stream_count", {32'(issued), 32'(got)}, {32'd20, 32'd20});
    chk("stream_empty", bus.resp_valid, 1'b0);
    bus.resp_ready = 1'b0;

    // Reset in the middle of init.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 60; i++) tick();
    chk("mid_addr", {RW0_en, RW0_addr}, {1'b1, 7'd60});
    #2 reset = 1'b0;
    #1 chk("mid_rst", {RW0_en, RW0_wmode, init_done}, '0);
    tick();
    reset = 1'b1;
    #1 chk("mid_wait", RW0_en, 1'b0);
    tick();
    run_init("reinit1");

    // Reset with one read in flight and one buffered.
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_addr = 7'd31;
    tick();
    bus.req_addr = 7'd32;
    tick();
    bus.req_valid = 1'b0;
    #1 chk("rd_pend", {bus.resp_valid, bus.req_ready}, {1'b1, 1'b0});
    reset = 1'b0;
    #1 chk("rd_rst", {bus.resp_valid, bus.req_ready}, '0);
    tick();
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    tick();
    run_init("reinit2");
    tick(); tick();
    chk("no_stale", bus.resp_valid, 1'b0);
    chk("zeroed", mem[31], '0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end
endmodule
